pc_redirect_ctrl: RTL and testbench

//  Receiving end of the branch-resolution interface. Consumes PcSel/BrPC/Halt from the EX-stage

---
 rtl/pc_redirect_ctrl_pkg.sv | 16 +
 rtl/pc_redirect_ctrl.sv | 115 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch-side PC redirect controller.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StWaitMem = 2'd1,
    StHalted  = 2'd2
  } fetch_state_e;

  localparam int unsigned InstrBytes = 4;

  function automatic logic target_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl.sv
// Owns the architectural PC and imem fetch request; applies EX-stage redirects and halts,
// buffering a redirect target while imem is not ready.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PcSel,
  input  logic [31:0]       BrPC,
  input  logic              Halt,
  input  logic              stall,
  input  logic              if_ready,
  output logic              if_req,
  output logic [PC_W-1:0]   PC,
  output logic              if_flush,
  output logic              id_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic              misalign_err
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             flush;
  logic [PC_W-1:0]  target;

  // Only the low PC_W bits of the target address are meaningful here.
  logic unused_brpc_hi;
  assign unused_brpc_hi = ^BrPC[31:PC_W];
  assign target         = BrPC[PC_W-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    flush   = 1'b0;
    unique case (state_q)
      StRun, StWaitMem: begin
        if (Halt) begin
          flush   = 1'b1;
          state_d = StHalted;
          pend_d  = '0;
        end else if (PcSel) begin
          // A taken redirect squashes younger instructions, including a stalled one in ID.
          flush = 1'b1;
          if (target_misaligned(BrPC[1:0])) begin
            mis_d   = 1'b1;
            state_d = StHalted;
            pend_d  = '0;
          end else begin
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (if_ready) begin
              pc_d    = target;
              pend_d  = '0;
              state_d = StRun;
            end else begin
              pend_d  = target;
              state_d = StWaitMem;
            end
          end
        end else if (state_q == StWaitMem) begin
          if (if_ready) begin
            pc_d    = pend_q;
            pend_d  = '0;
            state_d = StRun;
          end
        end else if (!stall && if_ready) begin
          pc_d = pc_q + PC_W'(InstrBytes);
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign if_req       = !reset && (state_q != StHalted) && !stall;
  assign if_flush     = !reset && flush;
  assign id_flush     = !reset && flush;
  assign PC           = pc_q;
  assign halted       = (state_q == StHalted);
  assign redirect_cnt = cnt_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench: a driver pushes expected per-cycle outputs from a behavioural model,
// a monitor pops and compares them against the DUT on the falling edge.
module tb_pc_redirect_ctrl;

  localparam int unsigned PC_W  = 9;
  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              PcSel;
  logic [31:0]       BrPC;
  logic              Halt;
  logic              stall;
  logic              if_ready;
  logic              if_req;
  logic [PC_W-1:0]   PC;
  logic              if_flush;
  logic              id_flush;
  logic              halted;
  logic [CNT_W-1:0]  redirect_cnt;
  logic              misalign_err;

  pc_redirect_ctrl #(
    .PC_W    (PC_W),
    .RESET_PC('0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PcSel       (PcSel),
    .BrPC        (BrPC),
    .Halt        (Halt),
    .stall       (stall),
    .if_ready    (if_ready),
    .if_req      (if_req),
    .PC          (PC),
    .if_flush    (if_flush),
    .id_flush    (id_flush),
    .halted      (halted),
    .redirect_cnt(redirect_cnt),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             if_req;
    logic             flush;
    logic [PC_W-1:0]  pc;
    logic             halted;
    logic [CNT_W-1:0] cnt;
    logic             mis;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Architectural model: a PC, a "halted" flag and an optional outstanding target.
  logic [PC_W-1:0]  m_pc;
  logic [PC_W-1:0]  m_pend;
  bit               m_pending;
  bit               m_halted;
  logic [CNT_W-1:0] m_cnt;
  bit               m_mis;

  task automatic model_reset();
    m_pc      = '0;
    m_pend    = '0;
    m_pending = 0;
    m_halted  = 0;
    m_cnt     = '0;
    m_mis     = 0;
  endtask

  task automatic step(input bit r, input bit ps, input logic [31:0] bp, input bit h,
                      input bit st, input bit rdy);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = r;
    PcSel    = ps;
    BrPC     = bp;
    Halt     = h;
    stall    = st;
    if_ready = rdy;
    e.if_req = !r && !m_halted && !st;
    e.flush  = !r && !m_halted && (h || ps);
    e.pc     = m_pc;
    e.halted = m_halted;
    e.cnt    = m_cnt;
    e.mis    = m_mis;
    sb.push_back(e);
    if (r) begin
      model_reset();
    end else if (!m_halted) begin
      if (h) begin
        m_halted  = 1;
        m_pending = 0;
      end else if (ps) begin
        if (bp[1:0] != 2'b00) begin
          m_mis     = 1;
          m_halted  = 1;
          m_pending = 0;
        end else begin
          if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
          if (rdy) begin
            m_pc      = bp[PC_W-1:0];
            m_pending = 0;
          end else begin
            m_pend    = bp[PC_W-1:0];
            m_pending = 1;
          end
        end
      end else if (m_pending) begin
        if (rdy) begin
          m_pc      = m_pend;
          m_pending = 0;
        end
      end else if (!st && rdy) begin
        m_pc = (m_pc + 4) % (1 << PC_W);
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, rdy);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("if_req",       32'(if_req),       32'(e.if_req));
      chk("if_flush",     32'(if_flush),     32'(e.flush));
      chk("id_flush",     32'(id_flush),     32'(e.flush));
      chk("PC",           32'(PC),           32'(e.pc));
      chk("halted",       32'(halted),       32'(e.halted));
      chk("redirect_cnt", 32'(redirect_cnt), 32'(e.cnt));
      chk("misalign_err", 32'(misalign_err), 32'(e.mis));
    end
  end

  initial begin
    reset = 1; PcSel = 0; BrPC = '0; Halt = 0; stall = 0; if_ready = 1;
    repeat (2) @(posedge clk);
    model_reset();

    // Sequential fetch from reset
    step(1, 0, 32'h0, 0, 0, 1);
    idle(5, 1);
    // Wrap at top of address space
    step(0, 1, 32'h1FC, 0, 0, 1);
    idle(3, 1);
    // Redirect accepted immediately
    step(0, 1, 32'h40, 0, 0, 1);
    idle(2, 1);
    // Redirect buffered while imem busy, then replaced during the wait
    step(0, 1, 32'h80, 0, 0, 0);
    idle(3, 0);
    step(0, 1, 32'hC0, 0, 0, 0);
    idle(2, 0);
    idle(2, 1);
    // Redirect beats stall; stall alone holds
    step(0, 1, 32'h20, 0, 1, 1);
    step(0, 0, 32'h0, 0, 1, 1);
    step(0, 0, 32'h0, 0, 1, 1);
    idle(1, 1);
    // Halt and freeze
    step(0, 0, 32'h0, 1, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 32'h100, 0, 0, 1);
    step(1, 0, 32'h0, 0, 0, 1);
    idle(2, 1);
    // Misaligned target
    step(0, 1, 32'h22, 0, 0, 1);
    idle(3, 1);
    step(1, 0, 32'h0, 0, 0, 1);
    idle(2, 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r, ps, h, st, rdy;
      logic [31:0] bp;
      r   = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      ps  = $urandom_range(0, 9) == 0;
      h   = $urandom_range(0, 59) == 0;
      st  = $urandom_range(0, 4) == 0;
      rdy = $urandom_range(0, 9) < 7;
      bp  = $urandom;
      if ($urandom_range(0, 7) != 0) bp[1:0] = 2'b00;
      step(r, ps, bp, h, st, rdy);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
